wb_mem_arbiter: RTL and testbench

- Shares one single-port 512x8 byte scratch memory between two requesters: the Wishbone slave port (management SoC) and a debug port driven from LA probes.
- Round-robin grant, one access at a time, fixed-latency ack per port.
- Sits between the user-project Wishbone and LA pins and the memory macro/array; owns all memory enable, write and address sequencing.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/wb_mem_arbiter_if.sv | 48 ++++
 rtl/rr_arb2.sv | 34 +++
 rtl/wb_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_wb_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the Wishbone/debug scratch memory arbiter.
// FSM states, requester ids and default memory geometry.
package mem_arb_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPT,
    RESP
  } state_e;

  typedef enum logic {
    PORT_WB  = 1'b0,
    PORT_DBG = 1'b1
  } port_e;

endpackage

// File: rtl/wb_mem_arbiter_if.sv
// Bundle of Wishbone slave, debug port and memory macro pins.
// slave = arbiter side, master = SoC/LA/memory side.
interface wb_mem_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
);

  logic              wbs_cyc_i;
  logic              wbs_stb_i;
  logic              wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_adr_i;
  logic [31:0]       wbs_dat_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
    input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i,
    output wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin: on a tie the port not served last wins.
// last_grant moves only on the update strobe.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  input  port_e      i_upd_id,
  output logic       o_gnt_vld,
  output port_e      o_gnt
);

  port_e r_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_last <= PORT_DBG;
    else if (i_upd) r_last <= i_upd_id;
  end

  always_comb begin
    o_gnt_vld = |i_req;
    o_gnt     = PORT_WB;
    unique case (1'b1)
      (i_req == 2'b11):
        o_gnt = (r_last == PORT_WB) ? PORT_DBG : PORT_WB;
      (i_req == 2'b01): o_gnt = PORT_WB;
      (i_req == 2'b10): o_gnt = PORT_DBG;
      default: o_gnt = PORT_WB;
    endcase
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Shares a single-port byte memory between Wishbone and a debug port.
// One access per grant: IDLE -> ISSUE -> CAPT -> RESP, ack registered.
module wb_mem_arbiter #(
  parameter int          ADDR_W    = 9,
  parameter int          DATA_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  wb_mem_arbiter_if.slave bus
);
  import mem_arb_pkg::*;

  state_e            r_state;
  state_e            w_next;
  port_e             r_port;
  logic              r_we;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_wb_rd;
  logic [DATA_W-1:0] r_dbg_rd;
  logic              r_wb_ack;
  logic              r_dbg_ack;

  logic       w_wb_req;
  logic       w_dbg_req;
  logic [1:0] w_req;
  logic       w_gnt_vld;
  port_e      w_gnt;
  logic       w_take;
  logic       w_upd;
  logic       w_ack_ok;
  logic       w_en;
  logic       w_unused;

  assign w_wb_req = bus.wbs_cyc_i & bus.wbs_stb_i
    & (bus.wbs_adr_i[31:ADDR_W] == BASE_ADDR[31:ADDR_W]);
  assign w_dbg_req = bus.dbg_req;

  // A port whose ack is still high is masked so it is not re-accepted.
  assign w_req = {w_dbg_req & ~r_dbg_ack, w_wb_req & ~r_wb_ack};

  assign w_unused = ^{bus.wbs_sel_i[3:1], bus.wbs_dat_i[31:DATA_W]};

  rr_arb2 u_arb (
    .i_clk     (wb_clk_i),
    .i_rst     (wb_rst_i),
    .i_req     (w_req),
    .i_upd     (w_upd),
    .i_upd_id  (r_port),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt     (w_gnt)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_take = 1'b0;
    w_upd  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_gnt_vld) begin
          w_take = 1'b1;
          w_next = ISSUE;
        end
      end
      ISSUE: w_next = CAPT;
      CAPT:  w_next = RESP;
      RESP: begin
        w_upd  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_ack_ok = (r_port == PORT_WB) ? w_wb_req : w_dbg_req;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_port  <= PORT_DBG;
      r_we    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_take) begin
      r_port <= w_gnt;
      if (w_gnt == PORT_WB) begin
        r_we    <= bus.wbs_we_i;
        r_wr    <= bus.wbs_we_i & bus.wbs_sel_i[0];
        r_addr  <= bus.wbs_adr_i[ADDR_W-1:0];
        r_wdata <= bus.wbs_dat_i[DATA_W-1:0];
      end else begin
        r_we    <= bus.dbg_we;
        r_wr    <= bus.dbg_we;
        r_addr  <= bus.dbg_addr;
        r_wdata <= bus.dbg_wdata;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_wb_rd   <= '0;
      r_dbg_rd  <= '0;
      r_wb_ack  <= 1'b0;
      r_dbg_ack <= 1'b0;
    end else begin
      if (r_state == CAPT && !r_we) begin
        if (r_port == PORT_WB) r_wb_rd <= bus.mem_rdata;
        else r_dbg_rd <= bus.mem_rdata;
      end
      r_wb_ack  <= (r_state == RESP) && (r_port == PORT_WB)
                   && w_ack_ok;
      r_dbg_ack <= (r_state == RESP) && (r_port == PORT_DBG)
                   && w_ack_ok;
    end
  end

  // Memory pins decode straight from state so reset kills them at once.
  assign w_en          = (r_state == ISSUE);
  assign bus.mem_en    = w_en;
  assign bus.mem_we    = w_en & r_wr;
  assign bus.mem_addr  = w_en ? r_addr : '0;
  assign bus.mem_wdata = w_en ? r_wdata : '0;

  assign bus.wbs_ack_o = r_wb_ack;
  assign bus.wbs_dat_o = {{(32-DATA_W){1'b0}}, r_wb_rd};
  assign bus.dbg_ack   = r_dbg_ack;
  assign bus.dbg_rdata = r_dbg_rd;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter with a behavioural 512x8 memory.
// Memory preload: mem[i] = i + 0x35 (so mem[7]=0x3C, mem[9]=0x3E).
module tb_wb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ld  = 1'b1;
  int   n_tot = 0;
  int   n_bad = 0;

  wb_mem_arbiter_if #(.ADDR_W(9), .DATA_W(8)) bus ();

  wb_mem_arbiter #(
    .ADDR_W    (9),
    .DATA_W    (8),
    .BASE_ADDR (32'h3000_0000)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [512];

  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'(i + 53);
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  int          s_lat;
  logic [31:0] s_rd;
  logic        s_en;
  logic        s_we;
  logic [8:0]  s_addr;
  logic [7:0]  s_wdata;
  logic        s_ack2;
  int          wa [4];
  int          da [4];
  int          nwa;
  int          nda;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [3:0] sel,
                         input logic [31:0] adr,
                         input logic [31:0] dat);
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sel;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    s_lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        s_en    = bus.mem_en;
        s_we    = bus.mem_we;
        s_addr  = bus.mem_addr;
        s_wdata = bus.mem_wdata;
      end
      if (bus.wbs_ack_o) begin
        s_lat = c;
        s_rd  = bus.wbs_dat_o;
        break;
      end
    end
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    @(posedge clk); #1;
    s_ack2 = bus.wbs_ack_o;
  endtask

  task automatic dbg_xfer(input logic we, input logic [8:0] adr,
                          input logic [7:0] dat, input int drop_at);
    @(posedge clk); #1;
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = we;
    bus.dbg_addr  = adr;
    bus.dbg_wdata = dat;
    s_lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        s_en   = bus.mem_en;
        s_we   = bus.mem_we;
        s_addr = bus.mem_addr;
      end
      if (c == drop_at) bus.dbg_req = 1'b0;
      if (bus.dbg_ack) begin
        s_lat = c;
        s_rd  = 32'(bus.dbg_rdata);
        break;
      end
    end
    bus.dbg_req = 1'b0;
    @(posedge clk); #1;
    s_ack2 = bus.dbg_ack;
  endtask

  task automatic pair_run(input logic [31:0] wadr,
                          input logic [8:0] dadr, input int n);
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h1;
    bus.wbs_adr_i = wadr;
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = 1'b0;
    bus.dbg_addr  = dadr;
    nwa = 0;
    nda = 0;
    for (int i = 0; i < 4; i++) begin
      wa[i] = 0;
      da[i] = 0;
    end
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o && nwa < 4) begin
        wa[nwa] = c;
        nwa++;
      end
      if (bus.dbg_ack && nda < 4) begin
        da[nda] = c;
        nda++;
      end
    end
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.dbg_req   = 1'b0;
  endtask

  initial begin
    int n_en;
    int n_ack;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 32'h0;
    bus.dbg_req   = 1'b0;
    bus.dbg_we    = 1'b0;
    bus.dbg_addr  = 9'h0;
    bus.dbg_wdata = 8'h0;

    #2;
    chk("rst_wbs_ack", 32'(bus.wbs_ack_o), 32'h0);
    chk("rst_dbg_ack", 32'(bus.dbg_ack), 32'h0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'h0);
    chk("rst_wbs_dat", bus.wbs_dat_o, 32'h0);
    chk("rst_dbg_rd", 32'(bus.dbg_rdata), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    ld  = 1'b0;
    rst = 1'b0;

    wb_xfer(1'b1, 4'h1, 32'h3000_0005, 32'h0000_00A5);
    chk("wr_lat", 32'(s_lat), 32'd4);
    chk("wr_en", 32'(s_en), 32'h1);
    chk("wr_we", 32'(s_we), 32'h1);
    chk("wr_addr", 32'(s_addr), 32'h5);
    chk("wr_data", 32'(s_wdata), 32'hA5);
    chk("wr_ack1cyc", 32'(s_ack2), 32'h0);
    chk("wr_mem5", 32'(mem[5]), 32'hA5);

    wb_xfer(1'b0, 4'h1, 32'h3000_0005, 32'h0);
    chk("rd_lat", 32'(s_lat), 32'd4);
    chk("rd_data", s_rd, 32'h0000_00A5);
    chk("rd_dbg_hold", 32'(bus.dbg_rdata), 32'h0);

    wb_xfer(1'b1, 4'h2, 32'h3000_0007, 32'h0000_00FF);
    chk("sel2_lat", 32'(s_lat), 32'd4);
    chk("sel2_en", 32'(s_en), 32'h1);
    chk("sel2_we", 32'(s_we), 32'h0);
    wb_xfer(1'b0, 4'h1, 32'h3000_0007, 32'h0);
    chk("sel2_rd", s_rd, 32'h0000_003C);

    dbg_xfer(1'b0, 9'd5, 8'h00, 0);
    chk("dbg_rd_lat", 32'(s_lat), 32'd4);
    chk("dbg_rd", s_rd, 32'hA5);
    chk("dbg_wb_hold", bus.wbs_dat_o, 32'h0000_003C);

    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_sel_i = 4'h1;
    bus.wbs_adr_i = 32'h4000_0000;
    n_en  = 0;
    n_ack = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.mem_en) n_en++;
      if (bus.wbs_ack_o) n_ack++;
    end
    chk("oow_mem_en", 32'(n_en), 32'h0);
    chk("oow_ack", 32'(n_ack), 32'h0);
    dbg_xfer(1'b1, 9'd3, 8'h77, 0);
    chk("oow_dbg_lat", 32'(s_lat), 32'd4);
    chk("oow_dbg_mem3", 32'(mem[3]), 32'h77);
    chk("oow_wb_ack", 32'(bus.wbs_ack_o), 32'h0);
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;

    dbg_xfer(1'b1, 9'd11, 8'h42, 2);
    chk("drop_noack", 32'(s_lat), 32'hFFFF_FFFF);
    chk("drop_mem11", 32'(mem[11]), 32'h42);

    pair_run(32'h3000_0005, 9'd3, 16);
    chk("alt_nwa", 32'(nwa), 32'd2);
    chk("alt_nda", 32'(nda), 32'd2);
    chk("alt_wb0", 32'(wa[0]), 32'd4);
    chk("alt_dbg0", 32'(da[0]), 32'd8);
    chk("alt_wb1", 32'(wa[1]), 32'd12);
    chk("alt_dbg1", 32'(da[1]), 32'd16);
    chk("alt_wb_rd", bus.wbs_dat_o, 32'h0000_00A5);
    chk("alt_dbg_rd", 32'(bus.dbg_rdata), 32'h77);

    @(posedge clk); #1;
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = 1'b1;
    bus.dbg_addr  = 9'd9;
    bus.dbg_wdata = 8'h55;
    @(posedge clk); #1;
    chk("iss_en", 32'(bus.mem_en), 32'h1);
    chk("iss_addr", 32'(bus.mem_addr), 32'h9);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_en", 32'(bus.mem_en), 32'h0);
    chk("ar_we", 32'(bus.mem_we), 32'h0);
    chk("ar_addr", 32'(bus.mem_addr), 32'h0);
    chk("ar_wdata", 32'(bus.mem_wdata), 32'h0);
    chk("ar_wbs_dat", bus.wbs_dat_o, 32'h0);
    chk("ar_dbg_rd", 32'(bus.dbg_rdata), 32'h0);
    bus.dbg_req = 1'b0;
    bus.dbg_we  = 1'b0;
    n_ack = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.dbg_ack || bus.wbs_ack_o) n_ack++;
    end
    chk("ar_noack", 32'(n_ack), 32'h0);
    rst = 1'b0;
    chk("ar_mem9", 32'(mem[9]), 32'h3E);

    pair_run(32'h3000_0009, 9'd5, 8);
    chk("pr_nwa", 32'(nwa), 32'd1);
    chk("pr_nda", 32'(nda), 32'd1);
    chk("pr_wb_first", 32'(wa[0]), 32'd4);
    chk("pr_dbg_next", 32'(da[0]), 32'd8);
    chk("pr_rd9", bus.wbs_dat_o, 32'h0000_003E);
    chk("pr_dbg_rd5", 32'(bus.dbg_rdata), 32'hA5);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
